demux12: RTL and testbench



---
 rtl/demux_pkg.sv | 12 +
 rtl/demux12_push_counter.sv | 21 ++
 rtl/demux12.sv | 123 ++++++++++++
 tb/tb_demux12.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared parameters and FSM state type for the two-way egress demultiplexer.
package demux_pkg;
   localparam int DATA_W_DEF  = 10;
   localparam int SEL_BIT_DEF = 9;
   localparam int CNT_W_DEF   = 8;

   typedef enum logic [1:0] {
      ST_INIT = 2'b00,
      ST_PASS = 2'b01,
      ST_HOLD = 2'b10
   } state_t;
endpackage

// File: rtl/demux12_push_counter.sv
// Wrapping push counter: increments once per cycle while en is high, wraps silently.
module push_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/demux12.sv
// Steers each accepted word to FIFO 0 or 1 by its selector bit; a word blocked by a full
// destination parks in a one-entry hold register while in_ready is dropped.
module demux12
   import demux_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SEL_BIT = SEL_BIT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              full0,
   input  logic              full1,
   output logic [DATA_W-1:0] out0,
   output logic              push0,
   output logic [DATA_W-1:0] out1,
   output logic              push1,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);
   state_t            state_q;
   logic [DATA_W-1:0] hold_q;
   logic              hold_dest_q;
   logic              in_ready_q;
   logic [DATA_W-1:0] out0_q, out1_q;
   logic              push0_q, push1_q;

   logic              in_dest;
   logic              in_full;
   logic              hold_full;
   logic              push0_d, push1_d;

   // Only the selected destination's full flag matters; the other one is ignored.
   always_comb begin
      in_dest   = in[SEL_BIT];
      in_full   = in_dest ? full1 : full0;
      hold_full = hold_dest_q ? full1 : full0;
      push0_d   = 1'b0;
      push1_d   = 1'b0;
      if (state_q == ST_PASS && in_valid && !in_full) begin
         push0_d = !in_dest;
         push1_d = in_dest;
      end else if (state_q == ST_HOLD && !hold_full) begin
         push0_d = !hold_dest_q;
         push1_d = hold_dest_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_INIT;
         hold_q      <= '0;
         hold_dest_q <= 1'b0;
         in_ready_q  <= 1'b0;
         out0_q      <= '0;
         out1_q      <= '0;
         push0_q     <= 1'b0;
         push1_q     <= 1'b0;
      end else begin
         push0_q <= push0_d;
         push1_q <= push1_d;
         case (state_q)
            ST_INIT: begin
               state_q    <= ST_PASS;
               in_ready_q <= 1'b1;
            end
            ST_PASS: begin
               if (in_valid) begin
                  if (in_full) begin
                     state_q     <= ST_HOLD;
                     hold_q      <= in;
                     hold_dest_q <= in_dest;
                     in_ready_q  <= 1'b0;
                  end else if (in_dest) begin
                     out1_q <= in;
                  end else begin
                     out0_q <= in;
                  end
               end
            end
            ST_HOLD: begin
               // in_ready was low this cycle, so no new word competes with the retry.
               if (!hold_full) begin
                  state_q    <= ST_PASS;
                  in_ready_q <= 1'b1;
                  if (hold_dest_q) begin
                     out1_q <= hold_q;
                  end else begin
                     out0_q <= hold_q;
                  end
               end
            end
            default: begin
               state_q    <= ST_INIT;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   push_counter #(.CNT_W(CNT_W)) u_cnt0 (
      .clk   (clk),
      .reset (reset),
      .en    (push0_d),
      .cnt   (cnt0)
   );

   push_counter #(.CNT_W(CNT_W)) u_cnt1 (
      .clk   (clk),
      .reset (reset),
      .en    (push1_d),
      .cnt   (cnt1)
   );

   assign in_ready = in_ready_q;
   assign out0     = out0_q;
   assign out1     = out1_q;
   assign push0    = push0_q;
   assign push1    = push1_q;
endmodule

// File: tb/tb_demux12.sv
// Directed bench for demux12: reset, streaming, hold/retry, reset during hold, counter wrap.
module tb_demux12;
   logic       clk;
   logic       reset;
   logic [9:0] in;
   logic       in_valid;
   logic       in_ready;
   logic       full0, full1;
   logic [9:0] out0, out1;
   logic       push0, push1;
   logic [7:0] cnt0, cnt1;

   int total = 0;
   int bad   = 0;

   demux12 dut (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .full0    (full0),
      .full1    (full1),
      .out0     (out0),
      .push0    (push0),
      .out1     (out1),
      .push1    (push1),
      .cnt0     (cnt0),
      .cnt1     (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in = '0; in_valid = 1'b0; full0 = 1'b0; full1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({in_ready, push0, push1, out0, out1, cnt0, cnt1} !== '0) begin
         bad++;
         $display("FAIL reset_vals got rdy=%b p0=%b p1=%b o0=%h o1=%h c0=%0d c1=%0d want all 0",
                  in_ready, push0, push1, out0, out1, cnt0, cnt1);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL rdy_before_edge got %b want 0", in_ready);
      end
      tick();
      total++;
      if (in_ready !== 1'b1 || push0 !== 1'b0 || push1 !== 1'b0) begin
         bad++;
         $display("FAIL rdy_after_release got rdy=%b p0=%b p1=%b want 1 0 0", in_ready, push0, push1);
      end
   endtask

   task automatic test_stream();
      logic [9:0] words [3];
      logic       dests [3];
      words[0] = 10'h005; words[1] = 10'h205; words[2] = 10'h0AA;
      dests[0] = 1'b0;    dests[1] = 1'b1;    dests[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in = words[i]; in_valid = 1'b1;
         tick();
         total++;
         if (push0 !== !dests[i] || push1 !== dests[i] ||
             (dests[i] ? out1 : out0) !== words[i]) begin
            bad++;
            $display("FAIL stream_%0d got p0=%b p1=%b o0=%h o1=%h want word %h on out%0d",
                     i, push0, push1, out0, out1, words[i], dests[i]);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      tick();
      total++;
      if (push0 !== 1'b0 || push1 !== 1'b0 || cnt0 !== 8'd2 || cnt1 !== 8'd1 || out0 !== 10'h0AA) begin
         bad++;
         $display("FAIL stream_end got p0=%b p1=%b c0=%0d c1=%0d o0=%h want 0 0 2 1 0aa",
                  push0, push1, cnt0, cnt1, out0);
      end
   endtask

   task automatic test_hold();
      @(negedge clk);
      full1 = 1'b1; in = 10'h3FF; in_valid = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b0 || push0 !== 1'b0 || push1 !== 1'b0) begin
         bad++;
         $display("FAIL hold_enter got rdy=%b p0=%b p1=%b want 0 0 0", in_ready, push0, push1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      tick();
      tick();
      total++;
      if (in_ready !== 1'b0 || push1 !== 1'b0 || cnt1 !== 8'd1) begin
         bad++;
         $display("FAIL hold_wait got rdy=%b p1=%b c1=%0d want 0 0 1", in_ready, push1, cnt1);
      end
      @(negedge clk);
      full1 = 1'b0;
      tick();
      total++;
      if (push1 !== 1'b1 || out1 !== 10'h3FF || in_ready !== 1'b1 || cnt1 !== 8'd2 || push0 !== 1'b0) begin
         bad++;
         $display("FAIL hold_release got p1=%b o1=%h rdy=%b c1=%0d p0=%b want 1 3ff 1 2 0",
                  push1, out1, in_ready, cnt1, push0);
      end
      tick();
      total++;
      if (push1 !== 1'b0 || out1 !== 10'h3FF) begin
         bad++; $display("FAIL hold_after got p1=%b o1=%h want 0 3ff", push1, out1);
      end
   endtask

   task automatic test_other_full();
      @(negedge clk);
      full1 = 1'b1; in = 10'h011; in_valid = 1'b1;
      tick();
      total++;
      if (push0 !== 1'b1 || out0 !== 10'h011 || push1 !== 1'b0 || in_ready !== 1'b1 || cnt0 !== 8'd3) begin
         bad++;
         $display("FAIL other_full got p0=%b o0=%h p1=%b rdy=%b c0=%0d want 1 011 0 1 3",
                  push0, out0, push1, in_ready, cnt0);
      end
      @(negedge clk);
      in_valid = 1'b0; full1 = 1'b0;
   endtask

   task automatic test_reset_in_hold();
      @(negedge clk);
      full1 = 1'b1; in = 10'h2AB; in_valid = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL rst_hold_enter got rdy=%b want 0", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      total++;
      if ({in_ready, push0, push1, out0, out1, cnt0, cnt1} !== '0) begin
         bad++;
         $display("FAIL async_reset got rdy=%b p0=%b p1=%b o0=%h o1=%h c0=%0d c1=%0d want all 0",
                  in_ready, push0, push1, out0, out1, cnt0, cnt1);
      end
      @(negedge clk);
      full1 = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (push1 !== 1'b0 || cnt1 !== 8'd0 || push0 !== 1'b0) begin
            bad++;
            $display("FAIL rst_drop_%0d got p1=%b c1=%0d p0=%b want 0 0 0", i, push1, cnt1, push0);
         end
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL rst_hold_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_wrap();
      int errs = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         in = 10'(i); in_valid = 1'b1;
         tick();
         if (push0 !== 1'b1 || out0 !== 10'(i) || cnt0 !== 8'(i + 1)) errs++;
      end
      total++;
      if (errs != 0 || cnt0 !== 8'd0) begin
         bad++; $display("FAIL wrap got errs=%0d c0=%0d want 0 0", errs, cnt0);
      end
      @(negedge clk);
      in = 10'h155;
      tick();
      total++;
      if (cnt0 !== 8'd1 || push0 !== 1'b1 || out0 !== 10'h155 || cnt1 !== 8'd0) begin
         bad++;
         $display("FAIL wrap_after got c0=%0d p0=%b o0=%h c1=%0d want 1 1 155 0", cnt0, push0, out0, cnt1);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_other_full();
      test_reset_in_hold();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   always @(negedge clk) begin
      if (reset && push0 === 1'b1 && push1 === 1'b1) begin
         total++;
         bad++;
         $display("FAIL both_push got p0=%b p1=%b want at most one", push0, push1);
      end
   end
endmodule
